// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Emits a registered match pulse and keeps a saturating match count.
module seq_detector_param #(
  parameter int                MAXLEN      = 16,
  parameter logic [MAXLEN-1:0] DEF_PATTERN = 16'h000D,
  parameter int                DEF_LEN     = 4,
  parameter int                DEF_OVERLAP = 1,
  parameter int                CNT_W       = 8,
  localparam int               LW          = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              w,
  input  logic              w_valid,
  input  logic              cfg_load,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  output logic              z,
  output logic [CNT_W-1:0]  match_count,
  output logic [LW-1:0]     fill
);

  logic [MAXLEN-1:0] pattern;
  logic [LW-1:0]     len;
  logic              overlap;

  // The oldest history bit is shifted out before it can ever be compared,
  // so only MAXLEN-1 bits are stored; hist_next is the full MAXLEN-bit view.
  logic [MAXLEN-2:0] hist;
  logic [MAXLEN-1:0] hist_next;
  logic [LW-1:0]     fill_next;
  logic [MAXLEN-1:0] len_mask;
  logic [LW-1:0]     cfg_len_eff;
  logic              accept;
  logic              match;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept    = w_valid && !cfg_load;
    hist_next = {hist, w};
    fill_next = (fill < len) ? fill + 1'b1 : len;
    len_mask  = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
    match = accept && (fill_next >= len) &&
            (((hist_next ^ pattern) & len_mask) == '0);
  end

  always_comb begin
    cfg_len_eff = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_eff = LW'(1);
    end else if (cfg_len > LW'(MAXLEN)) begin
      cfg_len_eff = LW'(MAXLEN);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      hist        <= '0;
      fill        <= '0;
      z           <= 1'b0;
      match_count <= '0;
      pattern     <= DEF_PATTERN;
      len         <= LW'(DEF_LEN);
      overlap     <= 1'(DEF_OVERLAP);
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= cfg_len_eff;
      overlap <= cfg_overlap;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
    end else begin
      z <= match;
      if (accept) begin
        hist <= hist_next[MAXLEN-2:0];
        fill <= (match && !overlap) ? '0 : fill_next;
      end
      if (match && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: defaults, overlap, gaps, config
// loads, counter saturation and mid-pattern reset.
module tb_seq_detector_param;

  localparam int MAXLEN = 16;
  localparam int LW     = $clog2(MAXLEN + 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic              w, w_valid, cfg_load, cfg_overlap;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LW-1:0]     cfg_len;
  logic              z;
  logic [7:0]        match_count;
  logic [LW-1:0]     fill;

  logic              s_reset, s_w, s_valid, s_load, s_overlap;
  logic [MAXLEN-1:0] s_pattern;
  logic [LW-1:0]     s_len;
  logic              s_z;
  logic [2:0]        s_count;
  logic [LW-1:0]     s_fill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .reset_n(reset_n), .w(w), .w_valid(w_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .z(z), .match_count(match_count), .fill(fill)
  );

  seq_detector_param #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset_n(s_reset), .w(s_w), .w_valid(s_valid),
    .cfg_load(s_load), .cfg_pattern(s_pattern), .cfg_len(s_len),
    .cfg_overlap(s_overlap), .z(s_z), .match_count(s_count), .fill(s_fill)
  );

  task automatic step(input logic b, input logic v);
    w = b; w_valid = v;
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
  endtask

  task automatic load(input logic [MAXLEN-1:0] p, input logic [LW-1:0] l,
                      input logic ov, input logic b, input logic v);
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_load = 1'b1;
    w = b; w_valid = v;
    @(posedge clk); #1;
    cfg_load = 1'b0; w_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z got=%b exp=0", z); end
    n_checks++; if (fill !== '0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    n_checks++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", match_count); end
  endtask

  task automatic test_defaults();
    logic [3:0] bits = 4'b1101;
    logic [3:0] ez   = 4'b0001;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      step(bits[i], 1'b1);
      n_checks++; if (z !== ez[i]) begin n_fail++; $display("FAIL def_z bit%0d got=%b exp=%b", 4 - i, z, ez[i]); end
      n_checks++; if (fill !== LW'(4 - i)) begin n_fail++; $display("FAIL def_fill bit%0d got=%0d exp=%0d", 4 - i, fill, 4 - i); end
    end
    n_checks++; if (match_count !== 8'd1) begin n_fail++; $display("FAIL def_count got=%0d exp=1", match_count); end
    step(1'b0, 1'b0);
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL def_idle_z got=%b exp=0", z); end
    n_checks++; if (fill !== LW'(4)) begin n_fail++; $display("FAIL def_idle_fill got=%0d exp=4", fill); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits  = 7'b1101101;
    logic [6:0] ez_ov = 7'b0001001;
    logic [6:0] ez_no = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(bits[i], 1'b1);
      n_checks++; if (z !== ez_ov[i]) begin n_fail++; $display("FAIL ovl_z bit%0d got=%b exp=%b", 7 - i, z, ez_ov[i]); end
    end
    n_checks++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL ovl_count got=%0d exp=2", match_count); end
    do_reset();
    load(16'h000D, LW'(4), 1'b0, 1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step(bits[i], 1'b1);
      n_checks++; if (z !== ez_no[i]) begin n_fail++; $display("FAIL novl_z bit%0d got=%b exp=%b", 7 - i, z, ez_no[i]); end
      if (i == 3) begin
        n_checks++; if (fill !== '0) begin n_fail++; $display("FAIL novl_fill_clear got=%0d exp=0", fill); end
      end
    end
    n_checks++; if (match_count !== 8'd1) begin n_fail++; $display("FAIL novl_count got=%0d exp=1", match_count); end
  endtask

  task automatic test_gaps();
    logic [7:0] bits  = 8'b10001001;
    logic [7:0] valid = 8'b10001101;
    logic [7:0] ez    = 8'b00000001;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      step(bits[i], valid[i]);
      n_checks++; if (z !== ez[i]) begin n_fail++; $display("FAIL gap_z step%0d got=%b exp=%b", 8 - i, z, ez[i]); end
    end
    n_checks++; if (match_count !== 8'd1) begin n_fail++; $display("FAIL gap_count got=%0d exp=1", match_count); end
  endtask

  task automatic test_config();
    logic [9:0]  p10 = 10'b1010100101;
    logic [15:0] p16 = 16'hA5C3;
    logic [2:0]  b1  = 3'b101;
    do_reset();
    load(16'h02A5, LW'(10), 1'b1, 1'b1, 1'b1);
    n_checks++; if (fill !== '0) begin n_fail++; $display("FAIL cfg_load_fill got=%0d exp=0", fill); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL cfg_load_z got=%b exp=0", z); end
    for (int i = 9; i >= 0; i--) begin
      step(p10[i], 1'b1);
      n_checks++; if (z !== (i == 0)) begin n_fail++; $display("FAIL cfg10_z bit%0d got=%b exp=%b", 10 - i, z, (i == 0)); end
    end
    n_checks++; if (fill !== LW'(10)) begin n_fail++; $display("FAIL cfg10_fill got=%0d exp=10", fill); end
    load(16'hFFF1, LW'(0), 1'b0, 1'b0, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      step(b1[i], 1'b1);
      n_checks++; if (z !== b1[i]) begin n_fail++; $display("FAIL len0_z bit%0d got=%b exp=%b", 3 - i, z, b1[i]); end
    end
    n_checks++; if (match_count !== 8'd3) begin n_fail++; $display("FAIL len0_count got=%0d exp=3", match_count); end
    load(p16, LW'(MAXLEN + 5), 1'b1, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      step(p16[i], 1'b1);
      n_checks++; if (z !== (i == 0)) begin n_fail++; $display("FAIL lenmax_z bit%0d got=%b exp=%b", 16 - i, z, (i == 0)); end
    end
    n_checks++; if (fill !== LW'(16)) begin n_fail++; $display("FAIL lenmax_fill got=%0d exp=16", fill); end
    n_checks++; if (match_count !== 8'd4) begin n_fail++; $display("FAIL lenmax_count got=%0d exp=4", match_count); end
  endtask

  task automatic test_saturation();
    s_reset = 1'b1;
    @(posedge clk); #1;
    s_reset = 1'b0;
    s_pattern = 16'h0001; s_len = LW'(1); s_overlap = 1'b1; s_load = 1'b1;
    @(posedge clk); #1;
    s_load = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      s_w = 1'b1; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      n_checks++; if (s_z !== 1'b1) begin n_fail++; $display("FAIL sat_z bit%0d got=%b exp=1", i, s_z); end
      n_checks++; if (s_count !== 3'((i < 7) ? i : 7)) begin n_fail++; $display("FAIL sat_count bit%0d got=%0d exp=%0d", i, s_count, (i < 7) ? i : 7); end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] bits = 4'b1101;
    logic [2:0] tail = 3'b101;
    do_reset();
    for (int i = 3; i >= 0; i--) step(bits[i], 1'b1);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    reset_n = 1'b1; cfg_load = 1'b1; cfg_pattern = 16'h0001; cfg_len = LW'(1);
    cfg_overlap = 1'b0; w = 1'b1; w_valid = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0; cfg_load = 1'b0; w_valid = 1'b0;
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL mrst_z got=%b exp=0", z); end
    n_checks++; if (fill !== '0) begin n_fail++; $display("FAIL mrst_fill got=%0d exp=0", fill); end
    n_checks++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL mrst_count got=%0d exp=0", match_count); end
    step(1'b1, 1'b1);
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL mrst_span_z got=%b exp=0", z); end
    n_checks++; if (fill !== LW'(1)) begin n_fail++; $display("FAIL mrst_span_fill got=%0d exp=1", fill); end
    for (int i = 2; i >= 0; i--) begin
      step(tail[i], 1'b1);
      n_checks++; if (z !== (i == 0)) begin n_fail++; $display("FAIL mrst_def_z bit%0d got=%b exp=%b", 3 - i, z, (i == 0)); end
    end
  endtask

  initial begin
    reset_n = 1'b1; w = 1'b0; w_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    s_reset = 1'b1; s_w = 1'b0; s_valid = 1'b0; s_load = 1'b0;
    s_pattern = '0; s_len = '0; s_overlap = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_defaults();
    test_overlap();
    test_gaps();
    test_config();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
